// File: rtl/wave_pkg.sv
// Shared definitions for the wave_pac_pipe DDS channel: waveform mode
// encoding, default widths and offset-binary midpoint / full-scale helpers.
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_t;

    localparam int DEF_ACC_W   = 32;
    localparam int DEF_PHASE_W = 10;
    localparam int DEF_AMP_W   = 8;
    localparam int DEF_LUT_AW  = DEF_PHASE_W - 2;

    // Offset-binary midpoint: 2^(aw-1)-1
    function automatic int unsigned amp_mid(input int aw);
        return (32'd1 << (aw - 1)) - 32'd1;
    endfunction

    // Offset-binary full scale: 2^aw-1
    function automatic int unsigned amp_max(input int aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM, 2^LUT_AW+1 entries, registered read (1 cycle).
// entry[i] = round(2^(AMP_W-1) * sin(pi/2 * i / 2^LUT_AW)); the extra top
// entry holds the exact peak 2^(AMP_W-1). Contents are built at elaboration
// from a fixed-point Taylor series, so no memory file is needed.
module sine_quarter_rom
    import wave_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int AMP_W  = DEF_AMP_W
) (
    input  logic              clk,
    input  logic [LUT_AW:0]   addr,
    output logic [AMP_W-1:0]  data
);

    localparam int     DEPTH       = (1 << LUT_AW) + 1;
    // pi/2 in Q2.30
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    // Rounded sine sample for table index i, evaluated in Q30 fixed point
    function automatic logic [AMP_W-1:0] sine_entry(input int i);
        longint x;
        longint term;
        longint sum;
        longint rnd;
        x    = (HALF_PI_Q30 * longint'(i)) >>> LUT_AW;
        term = x;
        sum  = x;
        for (int n = 1; n <= 8; n++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'(4 * n * n + 2 * n);
            sum  = sum + term;
        end
        rnd = ((sum <<< (AMP_W - 1)) + (longint'(1) <<< 29)) >>> 30;
        return AMP_W'(rnd);
    endfunction

    logic [AMP_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [AMP_W-1:0] ENTRY = sine_entry(i);
        assign rom[i] = ENTRY;
    end

    // Registered table read
    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/wave_pac_pipe.sv
// DDS channel: phase accumulator, phase offset, four-mode phase-to-amplitude
// converter (sine via quarter-wave ROM, square, triangle, sawtooth) with a
// valid strobe travelling alongside the samples. Latency tick -> out_valid
// is 3 cycles; defining WAVE_PAC_SCALE_EN adds a gain stage (latency 4).
module wave_pac_pipe
    import wave_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int AMP_W   = DEF_AMP_W,
    parameter int LUT_AW  = PHASE_W - 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               phase_clr,
    input  logic [ACC_W-1:0]   ftw,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [1:0]         mode,
    input  logic [AMP_W-1:0]   gain,
    output logic [AMP_W-1:0]   amplitude,
    output logic               out_valid
);

    localparam logic [AMP_W-1:0]  MID = AMP_W'(amp_mid(AMP_W));
    localparam logic [AMP_W-1:0]  MAX = AMP_W'(amp_max(AMP_W));
    localparam logic [LUT_AW:0]   QTR = (LUT_AW + 1)'(1) << LUT_AW;

    // Clamp a signed intermediate into the offset-binary range [0, MAX]
    function automatic logic [AMP_W-1:0] sat_amp(input logic signed [AMP_W+1:0] v);
        if (v < 0)
            return '0;
        else if (v > $signed({2'b00, MAX}))
            return MAX;
        else
            return v[AMP_W-1:0];
    endfunction

    // Triangle fold: 2p on the rising half, 2^(PW+1)-2p on the falling half
    function automatic logic [PHASE_W:0] fold(input logic [PHASE_W-1:0] p);
        return p[PHASE_W-1] ? ((PHASE_W + 1)'(0) - {p, 1'b0}) : {p, 1'b0};
    endfunction

    // Top AMP_W bits of the fold; the apex (exactly 2^PW) clamps to MAX
    function automatic logic [AMP_W-1:0] sat_tri(input logic [PHASE_W:0] f);
        logic [PHASE_W:0] sh;
        sh = f >> (PHASE_W - AMP_W);
        if (sh > (PHASE_W + 1)'(MAX))
            return MAX;
        else
            return sh[AMP_W-1:0];
    endfunction

    logic [ACC_W-1:0]   acc;
    logic [PHASE_W-1:0] p_next;
    logic [PHASE_W-1:0] p_p0;
    logic [PHASE_W-1:0] p_p1;
    mode_t              mode_p0;
    mode_t              mode_p1;
    logic               vld_p0;
    logic               vld_p1;
    logic [LUT_AW:0]    rom_idx;
    logic [AMP_W-1:0]   s_p1;
    logic [AMP_W-1:0]   wave_p1;

    assign p_next = (phase_clr ? '0 : acc[ACC_W-1 -: PHASE_W]) + phase_off;

    // ---- Stage 0: accumulate and sample truncated phase on tick ----
    // Accumulator and valid; reset wins over a simultaneous tick
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= tick;
            if (tick)
                acc <= (phase_clr ? '0 : acc) + ftw;
        end
    end

    // Phase and mode captured with the tick
    always_ff @(posedge clk) begin
        if (tick) begin
            p_p0    <= p_next;
            mode_p0 <= mode_t'(mode);
        end
    end

    // ---- Stage 1: quadrant fold into ROM index, registered lookup ----
    assign rom_idx = p_p0[PHASE_W-2] ? (QTR - {1'b0, p_p0[LUT_AW-1:0]})
                                     : {1'b0, p_p0[LUT_AW-1:0]};

    sine_quarter_rom #(
        .LUT_AW (LUT_AW),
        .AMP_W  (AMP_W)
    ) u_rom (
        .clk  (clk),
        .addr (rom_idx),
        .data (s_p1)
    );

    // Valid alongside the ROM read
    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end

    // Phase and mode alongside the ROM read
    always_ff @(posedge clk) begin
        p_p1    <= p_p0;
        mode_p1 <= mode_p0;
    end

    // ---- Stage 2: waveform select ----
    // Lower half-period adds the ROM sample to MID, upper half subtracts it
    always_comb begin
        wave_p1 = '0;
        case (mode_p1)
            MODE_SINE:   wave_p1 = sat_amp(p_p1[PHASE_W-1] ? ({2'b00, MID} - {2'b00, s_p1})
                                                           : ({2'b00, MID} + {2'b00, s_p1}));
            MODE_SQUARE: wave_p1 = p_p1[PHASE_W-1] ? '0 : MAX;
            MODE_TRI:    wave_p1 = sat_tri(fold(p_p1));
            MODE_SAW:    wave_p1 = p_p1[PHASE_W-1 -: AMP_W];
            default:     wave_p1 = '0;
        endcase
    end

`ifdef WAVE_PAC_SCALE_EN
    // Scale about MID: ((x-MID)*gain >>> (AW-1)) + MID; gain 2^(AW-1) is unity
    function automatic logic [AMP_W-1:0] scale_amp(input logic [AMP_W-1:0] x,
                                                   input logic [AMP_W-1:0] g);
        logic signed [AMP_W:0]     xc;
        logic signed [2*AMP_W+1:0] prod;
        logic signed [AMP_W+1:0]   y;
        xc   = $signed({1'b0, x}) - $signed({1'b0, MID});
        prod = (2 * AMP_W + 2)'(xc) * (2 * AMP_W + 2)'($signed({1'b0, g}));
        y    = (AMP_W + 2)'(prod >>> (AMP_W - 1)) + $signed({2'b00, MID});
        return sat_amp(y);
    endfunction

    logic [AMP_W-1:0] x_p2;
    logic             vld_p2;

    // ---- Stage 3: unscaled sample register ----
    // Valid into the gain stage
    always_ff @(posedge clk) begin
        if (reset)
            vld_p2 <= 1'b0;
        else
            vld_p2 <= vld_p1;
    end

    // Unscaled sample into the gain stage
    always_ff @(posedge clk) begin
        x_p2 <= wave_p1;
    end

    // ---- Stage 4: scaled output; amplitude holds between pulses ----
    // Output register with gain applied
    always_ff @(posedge clk) begin
        if (reset) begin
            amplitude <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_p2;
            if (vld_p2)
                amplitude <= scale_amp(x_p2, gain);
        end
    end
`else
    logic unused_gain;
    assign unused_gain = ^gain;

    // ---- Stage 3: output register; amplitude holds between pulses ----
    // Output register
    always_ff @(posedge clk) begin
        if (reset) begin
            amplitude <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1)
                amplitude <= wave_p1;
        end
    end
`endif

endmodule
